// File: rtl/ysyx_25040111_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Imported by the IFU interface, core and testbench.
package ysyx_25040111_ifu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [1:0]  RESP_OKAY    = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RESP = 3'd2,
    S_OUT  = 3'd3,
    S_NPC  = 3'd4
  } ifu_state_e;

  // Bundle handed to the IDU
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } if_id_t;

  function automatic logic pc_aligned(
    input logic [31:0] a
  );
    return a[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_25040111_ifu_if.sv
// Fetch-side bus: AXI4-Lite read channel, IDU handshake
// and the next-PC strobe coming back from WBU.
interface ysyx_25040111_ifu_if;
  import ysyx_25040111_ifu_pkg::*;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        fault;
  logic        inst_valid;
  logic        inst_ready;
  logic        npc_valid;
  logic [31:0] npc;

  modport master (
    output araddr, arvalid, rready,
    output inst, pc, fault, inst_valid,
    input  arready, rdata, rresp, rvalid,
    input  inst_ready, npc_valid, npc
  );

  modport slave (
    input  araddr, arvalid, rready,
    input  inst, pc, fault, inst_valid,
    output arready, rdata, rresp, rvalid,
    output inst_ready, npc_valid, npc
  );
endinterface

// File: rtl/ysyx_25040111_ifu.sv
// Multi-cycle instruction fetch unit: one AXI-Lite read per
// instruction, result held for the IDU until next PC returns.
module ysyx_25040111_ifu
  import ysyx_25040111_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  ysyx_25040111_ifu_if.master  bus,
  output logic [CNT_W-1:0]     fetch_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  ifu_state_e state_q, state_n;

  if_id_t           out_q, out_n;
  logic [31:0]      araddr_q, araddr_n;
  logic             arvalid_q, arvalid_n;
  logic             rready_q, rready_n;
  logic             ivalid_q, ivalid_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      out_q     <= '{inst: 32'h0, pc: RESET_PC, fault: 1'b0};
      araddr_q  <= RESET_PC;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ivalid_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_n;
      out_q     <= out_n;
      araddr_q  <= araddr_n;
      arvalid_q <= arvalid_n;
      rready_q  <= rready_n;
      ivalid_q  <= ivalid_n;
      cnt_q     <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    out_n     = out_q;
    araddr_n  = araddr_q;
    arvalid_n = arvalid_q;
    rready_n  = rready_q;
    ivalid_n  = ivalid_q;
    cnt_n     = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        arvalid_n = 1'b1;
        state_n   = S_REQ;
      end
      S_REQ: begin
        // address stays up until the slave takes it
        if (bus.arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rvalid) begin
          if (bus.rresp == RESP_OKAY) begin
            out_n.inst  = bus.rdata;
            out_n.fault = 1'b0;
          end else begin
            out_n.inst  = 32'h0;
            out_n.fault = 1'b1;
          end
          rready_n = 1'b0;
          ivalid_n = 1'b1;
          state_n  = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.inst_ready) begin
          ivalid_n = 1'b0;
          cnt_n    = cnt_q + CNT_ONE;
          state_n  = S_NPC;
        end
      end
      S_NPC: begin
        if (bus.npc_valid) begin
          out_n.pc = bus.npc;
          araddr_n = bus.npc;
          if (pc_aligned(bus.npc)) begin
            arvalid_n = 1'b1;
            state_n   = S_REQ;
          end else begin
            // misaligned target faults without touching the bus
            out_n.inst  = 32'h0;
            out_n.fault = 1'b1;
            ivalid_n    = 1'b1;
            state_n     = S_OUT;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.araddr     = araddr_q;
  assign bus.arvalid    = arvalid_q;
  assign bus.rready     = rready_q;
  assign bus.inst       = out_q.inst;
  assign bus.pc         = out_q.pc;
  assign bus.fault      = out_q.fault;
  assign bus.inst_valid = ivalid_q;
  assign fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_ysyx_25040111_ifu.sv
// Directed bench for the fetch unit: handshakes, bus errors,
// misaligned targets, back-pressure and mid-fetch reset.
module tb_ysyx_25040111_ifu;
  import ysyx_25040111_ifu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_cnt;
  int total = 0;
  int bad   = 0;

  ysyx_25040111_ifu_if bus();

  ysyx_25040111_ifu dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_araddr"}, bus.araddr, 32'h8000_0000);
    chk({tag, "_pc"}, bus.pc, 32'h8000_0000);
    chk({tag, "_arvalid"}, {31'h0, bus.arvalid}, 32'h0);
    chk({tag, "_rready"}, {31'h0, bus.rready}, 32'h0);
    chk({tag, "_ivalid"}, {31'h0, bus.inst_valid}, 32'h0);
    chk({tag, "_inst"}, bus.inst, 32'h0);
    chk({tag, "_fault"}, {31'h0, bus.fault}, 32'h0);
    chk({tag, "_cnt"}, fetch_cnt, 32'h0);
  endtask

  initial begin
    bus.arready    = 1'b0;
    bus.rdata      = 32'h0;
    bus.rresp      = 2'b00;
    bus.rvalid     = 1'b0;
    bus.inst_ready = 1'b0;
    bus.npc_valid  = 1'b0;
    bus.npc        = 32'h0;

    // 1: reset values, then a clean fetch at RESET_PC
    tick();
    tick();
    reset = 1'b0;
    chk_reset_vals("rst");
    bus.arready = 1'b1;
    tick();
    chk("t1_arvalid", {31'h0, bus.arvalid}, 32'h1);
    chk("t1_araddr", bus.araddr, 32'h8000_0000);
    tick();
    chk("t1_arvalid_dn", {31'h0, bus.arvalid}, 32'h0);
    chk("t1_rready", {31'h0, bus.rready}, 32'h1);
    bus.arready    = 1'b0;
    bus.rvalid     = 1'b1;
    bus.rdata      = 32'h0010_0093;
    bus.inst_ready = 1'b1;
    tick();
    bus.rvalid = 1'b0;
    chk("t1_ivalid", {31'h0, bus.inst_valid}, 32'h1);
    chk("t1_inst", bus.inst, 32'h0010_0093);
    chk("t1_pc", bus.pc, 32'h8000_0000);
    chk("t1_fault", {31'h0, bus.fault}, 32'h0);
    chk("t1_cnt_pre", fetch_cnt, 32'h0);
    tick();
    bus.inst_ready = 1'b0;
    chk("t1_cnt", fetch_cnt, 32'h1);
    chk("t1_ivalid_dn", {31'h0, bus.inst_valid}, 32'h0);

    // 2+3: slow address, slow data, error response
    bus.npc_valid = 1'b1;
    bus.npc       = 32'h8000_0004;
    tick();
    bus.npc_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_arvalid_hold", {31'h0, bus.arvalid}, 32'h1);
      chk("t2_araddr_hold", bus.araddr, 32'h8000_0004);
      tick();
    end
    chk("t2_arvalid_still", {31'h0, bus.arvalid}, 32'h1);
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    chk("t2_arvalid_dn", {31'h0, bus.arvalid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_rready_hold", {31'h0, bus.rready}, 32'h1);
      chk("t2_ivalid_lo", {31'h0, bus.inst_valid}, 32'h0);
    end
    bus.rvalid = 1'b1;
    bus.rresp  = 2'b10;
    bus.rdata  = 32'hdead_beef;
    tick();
    bus.rvalid = 1'b0;
    bus.rresp  = 2'b00;
    chk("t3_ivalid", {31'h0, bus.inst_valid}, 32'h1);
    chk("t3_inst", bus.inst, 32'h0);
    chk("t3_fault", {31'h0, bus.fault}, 32'h1);
    chk("t3_pc", bus.pc, 32'h8000_0004);

    // 5: IDU back-pressure, stray rvalid must not disturb output
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hffff_ffff;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_ivalid", {31'h0, bus.inst_valid}, 32'h1);
      chk("t5_inst", bus.inst, 32'h0);
      chk("t5_pc", bus.pc, 32'h8000_0004);
      chk("t5_arvalid", {31'h0, bus.arvalid}, 32'h0);
      chk("t5_cnt", fetch_cnt, 32'h1);
    end
    bus.rvalid     = 1'b0;
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk("t5_cnt_hs", fetch_cnt, 32'h2);
    chk("t5_ivalid_dn", {31'h0, bus.inst_valid}, 32'h0);

    // idle in S_NPC without a strobe
    tick();
    tick();
    chk("npc_wait_arvalid", {31'h0, bus.arvalid}, 32'h0);
    chk("npc_wait_ivalid", {31'h0, bus.inst_valid}, 32'h0);

    // 4: misaligned target faults without a bus request
    bus.npc_valid = 1'b1;
    bus.npc       = 32'h8000_0006;
    tick();
    bus.npc_valid = 1'b0;
    chk("t4_arvalid", {31'h0, bus.arvalid}, 32'h0);
    chk("t4_ivalid", {31'h0, bus.inst_valid}, 32'h1);
    chk("t4_fault", {31'h0, bus.fault}, 32'h1);
    chk("t4_pc", bus.pc, 32'h8000_0006);
    chk("t4_inst", bus.inst, 32'h0);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk("t4_cnt", fetch_cnt, 32'h3);

    // 6: reset while waiting for read data
    bus.npc_valid = 1'b1;
    bus.npc       = 32'h8000_0010;
    tick();
    bus.npc_valid = 1'b0;
    chk("t6_araddr", bus.araddr, 32'h8000_0010);
    chk("t6_arvalid", {31'h0, bus.arvalid}, 32'h1);
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    chk("t6_rready", {31'h0, bus.rready}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("t6_async");
    tick();
    reset = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h1234_5678;
    tick();
    bus.rvalid = 1'b0;
    chk("t6_arvalid_rst", {31'h0, bus.arvalid}, 32'h1);
    chk("t6_araddr_rst", bus.araddr, 32'h8000_0000);
    chk("t6_ivalid_rst", {31'h0, bus.inst_valid}, 32'h0);
    chk("t6_inst_rst", bus.inst, 32'h0);
    chk("t6_rready_rst", {31'h0, bus.rready}, 32'h0);
    chk("t6_cnt_rst", fetch_cnt, 32'h0);
    tick();
    chk("t6_still_req", {31'h0, bus.arvalid}, 32'h1);
    chk("t6_no_stale", {31'h0, bus.inst_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
